// File: rtl/maxnet_pkg.sv
`default_nettype none
// ============================================================================
// Module      : maxnet_pkg
// Description : Shared FSM state encoding and default sizing for the maxnet
//               activation feeder.
// Revision    : 1.0 - initial release
// ============================================================================
package maxnet_pkg;

    localparam int c_N_DEFAULT       = 4;
    localparam int c_DATA_W_DEFAULT  = 8;
    localparam int c_RES_W_DEFAULT   = 5;
    localparam int c_TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_FIRE = 2'd1,
        ST_WAIT = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/maxnet_feeder_if.sv
`default_nettype none
// ============================================================================
// Module      : maxnet_feeder_if
// Description : Upstream activation, maxnet and downstream result signals of
//               the feeder, bundled with modports for each side.
// Revision    : 1.0 - initial release
// ============================================================================
interface maxnet_feeder_if #(
    parameter int N      = maxnet_pkg::c_N_DEFAULT,
    parameter int DATA_W = maxnet_pkg::c_DATA_W_DEFAULT,
    parameter int RES_W  = maxnet_pkg::c_RES_W_DEFAULT
) ();

    logic                  in_valid;
    logic [DATA_W-1:0]     in_data;
    logic                  in_ready;
    logic                  mx_start;
    logic [N*DATA_W-1:0]   mx_data;
    logic                  mx_done;
    logic [RES_W-1:0]      mx_result;
    logic                  res_valid;
    logic [RES_W-1:0]      res_data;
    logic                  res_err;
    logic                  res_ready;
    logic                  busy;

    // Feeder side
    modport slave (
        input  in_valid, in_data, mx_done, mx_result, res_ready,
        output in_ready, mx_start, mx_data, res_valid, res_data, res_err, busy
    );

    // Environment side: upstream source, maxnet core and downstream sink
    modport master (
        output in_valid, in_data, mx_done, mx_result, res_ready,
        input  in_ready, mx_start, mx_data, res_valid, res_data, res_err, busy
    );

endinterface
`default_nettype wire

// File: rtl/feeder_slot_bank.sv
`default_nettype none
// ============================================================================
// Module      : feeder_slot_bank
// Description : N activation registers, one written per enabled cycle at the
//               given index, all presented on a flat read bus.
// Revision    : 1.0 - initial release
// ============================================================================
module feeder_slot_bank #(
    parameter int N      = maxnet_pkg::c_N_DEFAULT,
    parameter int DATA_W = maxnet_pkg::c_DATA_W_DEFAULT,
    parameter int IDX_W  = $clog2(maxnet_pkg::c_N_DEFAULT)
) (
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire logic                we,
    input  wire logic [IDX_W-1:0]    idx,
    input  wire logic [DATA_W-1:0]   wdata,
    output logic      [N*DATA_W-1:0] rdata
);

    for (genvar k = 0; k < N; k++) begin : g_slot
        logic [DATA_W-1:0] r_slot;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_slot <= '0;
            end else if (we && (idx == IDX_W'(k))) begin
                r_slot <= wdata;
            end
        end

        assign rdata[k*DATA_W +: DATA_W] = r_slot;
    end

endmodule
`default_nettype wire

// File: rtl/maxnet_feeder.sv
`default_nettype none
// ============================================================================
// Module      : maxnet_feeder
// Description : Buffers N activations, fires maxnet, waits for its result
//               under a watchdog and hands the result downstream.
// Revision    : 1.0 - initial release
// ============================================================================
module maxnet_feeder
    import maxnet_pkg::*;
#(
    parameter int N       = c_N_DEFAULT,
    parameter int DATA_W  = c_DATA_W_DEFAULT,
    parameter int RES_W   = c_RES_W_DEFAULT,
    parameter int TIMEOUT = c_TIMEOUT_DEFAULT
) (
    input  wire logic         clk,
    input  wire logic         rst,
    maxnet_feeder_if.slave    bus
);

    localparam int IDX_W = $clog2(N);
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(N - 1);
    localparam logic [WD_W-1:0]  c_timeout  = WD_W'(TIMEOUT);

    state_t             r_state;
    logic [IDX_W-1:0]   r_idx;
    logic [WD_W-1:0]    r_wd;
    logic [RES_W-1:0]   r_res_data;
    logic               r_res_err;

    logic               w_in_ready;
    logic               w_accept;
    logic [WD_W-1:0]    w_wd_next;
    logic [N*DATA_W-1:0] w_slots;

    // Gated by reset so upstream never sees ready while the block is held.
    assign w_in_ready = rst && (r_state == ST_LOAD);
    assign w_accept   = w_in_ready && bus.in_valid;
    assign w_wd_next  = r_wd + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_LOAD;
            r_idx      <= '0;
            r_wd       <= '0;
            r_res_data <= '0;
            r_res_err  <= 1'b0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (w_accept) begin
                        if (r_idx == c_idx_last) begin
                            r_idx   <= '0;
                            r_state <= ST_FIRE;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                ST_FIRE: begin
                    r_wd    <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_wd <= w_wd_next;
                    // A completion in the expiry cycle still takes priority.
                    if (bus.mx_done) begin
                        r_res_data <= bus.mx_result;
                        r_res_err  <= 1'b0;
                        r_state    <= ST_OUT;
                    end else if (w_wd_next == c_timeout) begin
                        r_res_data <= '1;
                        r_res_err  <= 1'b1;
                        r_state    <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (bus.res_ready) begin
                        r_state <= ST_LOAD;
                    end
                end
                default: begin
                    r_state <= ST_LOAD;
                end
            endcase
        end
    end

    feeder_slot_bank #(
        .N      (N),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_slot_bank (
        .clk   (clk),
        .rst   (rst),
        .we    (w_accept),
        .idx   (r_idx),
        .wdata (bus.in_data),
        .rdata (w_slots)
    );

    assign bus.in_ready  = w_in_ready;
    assign bus.mx_start  = (r_state == ST_FIRE);
    assign bus.mx_data   = w_slots;
    assign bus.res_valid = (r_state == ST_OUT);
    assign bus.res_data  = r_res_data;
    assign bus.res_err   = r_res_err;
    assign bus.busy      = (r_state != ST_LOAD);

endmodule
`default_nettype wire

// File: tb/tb_maxnet_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_maxnet_feeder
// Description : Directed scoreboard bench for maxnet_feeder; the sequence
//               queues expected starts/results, a monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_maxnet_feeder;

    localparam int N      = 4;
    localparam int DATA_W = 8;
    localparam int RES_W  = 5;

    logic clk;
    logic rst;

    maxnet_feeder_if #(.N(N), .DATA_W(DATA_W), .RES_W(RES_W)) bus ();

    maxnet_feeder #(
        .N       (N),
        .DATA_W  (DATA_W),
        .RES_W   (RES_W),
        .TIMEOUT (255)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [N*DATA_W-1:0] exp_start_q[$];
    logic [RES_W:0]      exp_res_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Loads four activations, optionally with two idle cycles after each one
    // and an out-of-turn mx_done raised during those idle cycles.
    task automatic load4(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d,
                         input bit gap, input bit spur);
        logic [7:0] v[4];
        v = '{a, b, c, d};
        for (int i = 0; i < 4; i++) begin
            check("in_ready_load", bus.in_ready, 1'b1);
            bus.in_valid = 1'b1;
            bus.in_data  = v[i];
            step();
            if (gap && i < 3) begin
                bus.in_valid  = 1'b0;
                bus.in_data   = 8'hEE;
                bus.mx_done   = spur;
                bus.mx_result = 5'd3;
                step();
                step();
                bus.mx_done   = 1'b0;
            end
        end
        bus.in_valid = 1'b0;
        exp_start_q.push_back({d, c, b, a});
    endtask

    // Entered in the FIRE cycle; raises mx_done after wait_cycles WAIT cycles.
    task automatic fire_and_done(input int wait_cycles, input logic [RES_W-1:0] res);
        check("mx_start_pulse", bus.mx_start, 1'b1);
        check("busy_fire", bus.busy, 1'b1);
        step();
        check("mx_start_drop", bus.mx_start, 1'b0);
        repeat (wait_cycles) step();
        bus.mx_done   = 1'b1;
        bus.mx_result = res;
        exp_res_q.push_back({res, 1'b0});
        step();
        bus.mx_done   = 1'b0;
        check("res_valid_rise", bus.res_valid, 1'b1);
        step();
        check("res_valid_one_cycle", bus.res_valid, 1'b0);
        check("in_ready_back", bus.in_ready, 1'b1);
    endtask

    // Monitor: compares each start against its queued slot image, checks the
    // slots stay frozen while busy, and pops results on each handshake.
    initial begin : monitor
        logic [N*DATA_W-1:0] held;
        logic [RES_W:0]      er;
        bit                  held_on;
        held_on = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                held_on = 1'b0;
            end else begin
                if (bus.mx_start) begin
                    if (exp_start_q.size() == 0) begin
                        check("unexpected_mx_start", 1'b1, 1'b0);
                    end else begin
                        check("mx_data_at_start", bus.mx_data, exp_start_q.pop_front());
                    end
                    held    = bus.mx_data;
                    held_on = 1'b1;
                end else if (held_on && bus.busy) begin
                    check("mx_data_stable", bus.mx_data, held);
                end else if (!bus.busy) begin
                    held_on = 1'b0;
                end
                if (bus.res_valid && bus.res_ready) begin
                    if (exp_res_q.size() == 0) begin
                        check("unexpected_result", {bus.res_data, bus.res_err}, 6'h3F);
                    end else begin
                        er = exp_res_q.pop_front();
                        check("result_data", bus.res_data, er[RES_W:1]);
                        check("result_err", bus.res_err, er[0]);
                    end
                end
            end
        end
    end

    initial begin : guard
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin : sequence_main
        int  cnt;
        bit  ir_bad;

        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.mx_done   = 1'b0;
        bus.mx_result = '0;
        bus.res_ready = 1'b1;
        step();
        step();
        check("rst_in_ready", bus.in_ready, 1'b0);
        check("rst_outputs", {bus.mx_start, bus.res_valid, bus.busy}, 3'b000);
        check("rst_mx_data", bus.mx_data, '0);
        check("rst_result", {bus.res_data, bus.res_err}, 6'h00);
        rst = 1'b1;
        step();
        check("idle_in_ready", bus.in_ready, 1'b1);
        check("idle_busy", bus.busy, 1'b0);

        // Held in_valid, result two cycles after start.
        load4(8'd3, 8'd7, 8'd2, 8'd5, 1'b0, 1'b0);
        fire_and_done(1, 5'd7);

        // Extreme activation values, shortest latency, all-ones result that
        // is not a timeout.
        load4(8'h80, 8'h7F, 8'hFF, 8'h00, 1'b0, 1'b0);
        fire_and_done(0, 5'h1F);

        // Watchdog expiry followed by a stalled downstream.
        load4(8'd1, 8'd2, 8'd3, 8'd4, 1'b0, 1'b0);
        bus.res_ready = 1'b0;
        exp_res_q.push_back({5'h1F, 1'b1});
        check("mx_start_timeout_run", bus.mx_start, 1'b1);
        step();
        cnt    = 0;
        ir_bad = 1'b0;
        while (!bus.res_valid && cnt < 400) begin
            cnt++;
            if (bus.in_ready || !bus.busy) ir_bad = 1'b1;
            step();
        end
        check("timeout_wait_cycles", cnt, 255);
        check("in_ready_low_in_wait", ir_bad, 1'b0);
        for (int i = 0; i < 10; i++) begin
            check("out_hold", {bus.res_valid, bus.res_data, bus.res_err, bus.in_ready},
                  {1'b1, 5'h1F, 1'b1, 1'b0});
            bus.in_valid = i[0];
            bus.in_data  = 8'hA0 + 8'(i);
            bus.mx_done  = ~i[0];
            step();
        end
        bus.in_valid  = 1'b0;
        bus.mx_done   = 1'b0;
        bus.res_ready = 1'b1;
        step();
        check("out_released", bus.res_valid, 1'b0);

        // Completion in the very cycle the watchdog expires.
        load4(8'd11, 8'd12, 8'd13, 8'd14, 1'b0, 1'b0);
        fire_and_done(254, 5'd9);

        // Gapped input with mx_done raised while loading.
        load4(8'd9, 8'd8, 8'd7, 8'd6, 1'b1, 1'b1);
        fire_and_done(2, 5'd2);

        // Reset in WAIT with a stale completion, then a fresh run.
        load4(8'd21, 8'd22, 8'd23, 8'd24, 1'b0, 1'b0);
        step();
        step();
        check("busy_wait", bus.busy, 1'b1);
        rst           = 1'b0;
        bus.mx_done   = 1'b1;
        bus.mx_result = 5'd20;
        #1;
        check("midrun_rst_outputs",
              {bus.in_ready, bus.mx_start, bus.res_valid, bus.busy}, 4'b0000);
        check("midrun_rst_slots", bus.mx_data, '0);
        step();
        rst = 1'b1;
        step();
        step();
        check("stale_done_ignored", {bus.res_valid, bus.busy, bus.in_ready}, 3'b001);
        bus.mx_done = 1'b0;
        load4(8'd1, 8'd1, 8'd1, 8'd1, 1'b0, 1'b0);
        fire_and_done(1, 5'd1);

        step();
        step();
        check("res_queue_drained", exp_res_q.size(), 0);
        check("start_queue_drained", exp_start_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/maxnet_feeder.md
MAXNET_FEEDER -- requirements
Module: maxnet_feeder

Interface
REQ-001 Parameter N, default 4, is the number of activations per maxnet run, with N >= 2.
REQ-002 Parameter DATA_W, default 8, is the width of one activation (two's complement, passed through unmodified).
REQ-003 Parameter RES_W, default 5, is the width of the maxnet result.
REQ-004 Parameter TIMEOUT, default 255, is the maximum number of cycles to wait for mx_done.
REQ-005 Port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-006 Port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-007 Port in_valid, input, 1 bit: an upstream activation is present.
REQ-008 Port in_data, input, DATA_W bits: the upstream activation.
REQ-009 Port in_ready, output, 1 bit: the block accepts in_data this cycle.
REQ-010 Port mx_start, output, 1 bit: start pulse to maxnet.
REQ-011 Port mx_data, output, N*DATA_W bits: the buffered activations, with slot k at bits [k*DATA_W +: DATA_W].
REQ-012 Port mx_done, input, 1 bit: maxnet completion.
REQ-013 Port mx_result, input, RES_W bits: maxnet result, valid while mx_done is high.
REQ-014 Port res_valid, output, 1 bit: a result is available downstream.
REQ-015 Port res_data, output, RES_W bits: the captured result.
REQ-016 Port res_err, output, 1 bit: the result came from a timeout, not from maxnet.
REQ-017 Port res_ready, input, 1 bit: downstream accepts the result.
REQ-018 Port busy, output, 1 bit: high in every state except LOAD.

Function
REQ-019 The FSM SHALL have the states LOAD, FIRE, WAIT and OUT, and SHALL enter LOAD on reset.
REQ-020 LOAD: in_ready = 1; on in_valid & in_ready, the block SHALL write in_data to slot[idx] and increment idx.
REQ-021 When a write occurs with idx == N-1, the FSM SHALL go to FIRE next cycle and clear idx to 0.
REQ-022 In every state other than LOAD, in_ready SHALL be 0 and in_data SHALL be ignored.
REQ-023 FIRE SHALL last exactly one cycle: mx_start = 1, watchdog cleared, next state WAIT.
REQ-024 mx_start SHALL be 0 in all states other than FIRE (single-cycle pulse).
REQ-025 mx_data SHALL be driven directly from the slot registers and SHALL stay stable from FIRE until OUT exits.
REQ-026 In WAIT, mx_done = 1 SHALL capture mx_result into res_data, set res_err = 0, and move the FSM to OUT.
REQ-027 The block SHALL sample mx_done only in WAIT; an mx_done seen in LOAD, FIRE or OUT SHALL be ignored.
REQ-028 In WAIT the watchdog SHALL increment each cycle; if it reaches TIMEOUT with mx_done low, res_data SHALL be set to all ones, res_err to 1, and the FSM SHALL go to OUT.
REQ-029 If mx_done arrives in the same cycle the watchdog reaches TIMEOUT, the result from mx_done SHALL win (res_err = 0).
REQ-030 OUT: res_valid = 1, with res_data and res_err held; on res_ready the FSM SHALL return to LOAD next cycle.
REQ-031 res_valid SHALL not drop until res_ready is sampled high, and no new activation SHALL be accepted before that handshake.
REQ-032 Minimum latency SHALL be: last input accepted at cycle t -> mx_start at t+1 -> earliest res_valid at t+3, given mx_done at t+2.
REQ-033 The watchdog SHALL be ceil(log2(TIMEOUT+1)) bits wide; idx SHALL be ceil(log2(N)) bits wide and never exceed N-1.

Reset
REQ-034 On rst low, asynchronously: state = LOAD, idx = 0, watchdog = 0, all slots = 0, res_data = 0, res_err = 0.
REQ-035 Outputs during reset: in_ready = 0, mx_start = 0, res_valid = 0, busy = 0.
REQ-036 Reset asserted mid-operation (FIRE, WAIT or OUT) SHALL abandon the run; a later mx_done SHALL be ignored until the next FIRE.

Structure
REQ-037 The state encoding and the default values of N, DATA_W, RES_W and TIMEOUT SHALL live in a shared package, maxnet_pkg.
REQ-038 The FSM and datapath SHALL be in one module; the slot bank SHALL be the single sub-module feeder_slot_bank (write enable, index, flat read bus).

Verification
REQ-039 Load 3, 7, 2, 5 with in_valid held high -> mx_start pulse one cycle after the 4th accept; mx_data = {5,2,7,3}.
REQ-040 Stub mx_done = 1 two cycles after start with mx_result = 5'd7, res_ready = 1 -> res_valid one cycle, res_data = 7, res_err = 0.
REQ-041 Stub never asserts mx_done -> after 255 WAIT cycles res_data = 5'h1F, res_err = 1; in_ready = 0 throughout.
REQ-042 Hold res_ready = 0 for 10 cycles in OUT -> res_valid and res_data stable, in_valid pulses ignored, idx stays 0.
REQ-043 Gap in_valid (accept, 0, 0, accept ...) -> slots fill in order; a spurious mx_done during LOAD changes nothing.
REQ-044 Assert rst in WAIT, release, then load 1, 1, 1, 1 -> the old mx_done is ignored and the new run completes normally.
